// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    ISSUE,
    WAIT,
    VALID
  } fetch_state_t;

  localparam int INSTR_BYTES = 4;
  localparam int IDX_W       = 2;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Memory, redirect and decode-side signals of the fetch unit.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 10
);

  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_pc;

  modport master (
    output mem_addr, out_valid, out_instr, out_pc,
    input  mem_rdata, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  mem_addr, out_valid, out_instr, out_pc,
    output mem_rdata, redirect_valid, redirect_pc, out_ready
  );

endinterface

// File: rtl/instr_fetch_unit_assembler.sv
// Little-endian byte assembly register: writes one byte lane per capture.
module instr_byte_assembler
  import fetch_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             cap_en,
  input  logic [IDX_W-1:0] cap_idx,
  input  logic [7:0]       rdata,
  output logic [31:0]      word_q,
  output logic [31:0]      word_merged
);

  // Current word with this cycle's captured byte merged into its lane.
  always_comb begin
    word_merged = word_q;
    if (cap_en) begin
      word_merged[{cap_idx, 3'b000} +: 8] = rdata;
    end
  end

  // Register the merged word.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
    end else begin
      word_q <= word_merged;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch engine: issues four byte reads per instruction, assembles them
// little-endian and hands the word to decode over valid/ready.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int              ADDR_W   = 10,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic              clk,
  input logic              rst,
  instr_fetch_unit_if.master bus
);

  fetch_state_t      state;
  logic [IDX_W-1:0]  idx;
  logic [ADDR_W-1:0] pc;
  logic              cap_flag;
  logic [IDX_W-1:0]  cap_idx;
  logic              out_valid_q;
  logic [31:0]       out_instr_q;
  logic [ADDR_W-1:0] out_pc_q;
  logic [31:0]       word_q;
  logic [31:0]       word_merged;

  instr_byte_assembler u_asm (
    .clk         (clk),
    .rst         (rst),
    .cap_en      (cap_flag),
    .cap_idx     (cap_idx),
    .rdata       (bus.mem_rdata),
    .word_q      (word_q),
    .word_merged (word_merged)
  );

  // Byte address decoded from registered state only; wraps with ADDR_W.
  always_comb begin
    bus.mem_addr = pc;
    if (state == ISSUE) begin
      bus.mem_addr = pc + ADDR_W'(idx);
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = out_instr_q;
  assign bus.out_pc    = out_pc_q;

  // Fetch FSM; redirect outranks every transition, reset outranks redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ISSUE;
      idx         <= '0;
      pc          <= RESET_PC;
      cap_flag    <= 1'b0;
      cap_idx     <= '0;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_pc_q    <= '0;
    end else if (bus.redirect_valid) begin
      // A handshake in this cycle still completes; only the next pc changes.
      state       <= ISSUE;
      idx         <= '0;
      pc          <= bus.redirect_pc;
      cap_flag    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        ISSUE: begin
          cap_flag <= 1'b1;
          cap_idx  <= idx;
          idx      <= idx + IDX_W'(1);
          if (idx == IDX_W'(INSTR_BYTES - 1)) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          cap_flag    <= 1'b0;
          out_instr_q <= word_merged;
          out_pc_q    <= pc;
          out_valid_q <= 1'b1;
          state       <= VALID;
        end
        VALID: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            pc          <= pc + ADDR_W'(INSTR_BYTES);
            idx         <= '0;
            state       <= ISSUE;
          end
        end
        default: begin
          state <= ISSUE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit with a registered-read byte memory.
module tb_instr_fetch_unit;

  typedef struct packed {
    logic [31:0] instr;
    logic [9:0]  pc;
  } exp_t;

  logic clk;
  logic rst;
  logic [7:0] mem [1024];

  exp_t sbq[$];
  exp_t e;
  int   total    = 0;
  int   bad      = 0;
  int   hs_count = 0;

  instr_fetch_unit_if #(.ADDR_W(10)) bus ();

  instr_fetch_unit #(
    .ADDR_W   (10),
    .RESET_PC (10'h000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read memory: byte appears the cycle after its address.
  always @(posedge clk) bus.mem_rdata <= mem[bus.mem_addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string nm, input int exp_lat);
    int n;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      tick();
      n++;
    end
    chk(nm, n, exp_lat);
  endtask

  // Monitor: every accepted instruction is compared against the queue head.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      hs_count++;
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_empty: got handshake pc=0x%0h instr=0x%0h expected none",
                 bus.out_pc, bus.out_instr);
      end else begin
        e = sbq.pop_front();
        chk("sb_instr", bus.out_instr, e.instr);
        chk("sb_pc", 32'(bus.out_pc), 32'(e.pc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'hA0; mem[3] = 8'h00;
    mem[4] = 8'h11; mem[5] = 8'h22; mem[6] = 8'h33; mem[7] = 8'h44;
    mem[10'h100] = 8'h01; mem[10'h101] = 8'h02;
    mem[10'h102] = 8'h03; mem[10'h103] = 8'h04;
    mem[10'h200] = 8'hEF; mem[10'h201] = 8'hBE;
    mem[10'h202] = 8'hAD; mem[10'h203] = 8'hDE;

    rst = 1'b1;
    bus.out_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    repeat (3) tick();
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_instr", bus.out_instr, 32'd0);
    chk("rst_pc", 32'(bus.out_pc), 32'd0);
    chk("rst_addr", 32'(bus.mem_addr), 32'd0);

    // First fetch from reset, decode stalled for ten cycles.
    sbq.push_back('{instr: 32'h00A00513, pc: 10'h000});
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("issue_addr", 32'(bus.mem_addr), 32'(c));
      if (c < 3) tick();
    end
    wait_valid("first_latency", 2);
    for (int c = 0; c < 10; c++) begin
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_instr", bus.out_instr, 32'h00A00513);
      chk("hold_pc", 32'(bus.out_pc), 32'd0);
      chk("hold_addr", 32'(bus.mem_addr), 32'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    sbq.push_back('{instr: 32'h44332211, pc: 10'h004});
    tick();
    chk("next_addr", 32'(bus.mem_addr), 32'h004);
    chk("next_valid_low", 32'(bus.out_valid), 32'd0);
    wait_valid("ready_latency", 5);

    // Redirect in cycle 2 of the fetch at 0x008.
    tick();
    chk("b_addr0", 32'(bus.mem_addr), 32'h008);
    tick();
    chk("b_addr1", 32'(bus.mem_addr), 32'h009);
    tick();
    chk("b_addr2", 32'(bus.mem_addr), 32'h00A);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 10'h100;
    sbq.push_back('{instr: 32'h04030201, pc: 10'h100});
    tick();
    bus.redirect_valid = 1'b0;
    chk("redirect_addr", 32'(bus.mem_addr), 32'h100);
    wait_valid("redirect_latency", 5);

    // Wrapping fetch at 0x3FE, then sequential fetch at 0x002.
    mem[10'h3FE] = 8'hAA; mem[10'h3FF] = 8'hBB;
    mem[0] = 8'hCC; mem[1] = 8'hDD;
    mem[2] = 8'h5A; mem[3] = 8'h6B; mem[4] = 8'h7C; mem[5] = 8'h8D;
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 10'h3FE;
    sbq.push_back('{instr: 32'hDDCCBBAA, pc: 10'h3FE});
    sbq.push_back('{instr: 32'h8D7C6B5A, pc: 10'h002});
    tick();
    bus.redirect_valid = 1'b0;
    chk("wrap_addr0", 32'(bus.mem_addr), 32'h3FE);
    tick();
    chk("wrap_addr1", 32'(bus.mem_addr), 32'h3FF);
    tick();
    chk("wrap_addr2", 32'(bus.mem_addr), 32'h000);
    tick();
    chk("wrap_addr3", 32'(bus.mem_addr), 32'h001);
    wait_valid("wrap_latency", 2);
    tick();
    chk("after_wrap_addr", 32'(bus.mem_addr), 32'h002);
    wait_valid("after_wrap_latency", 5);

    // Redirect coinciding with a handshake: that instruction is kept.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 10'h200;
    sbq.push_back('{instr: 32'hDEADBEEF, pc: 10'h200});
    tick();
    bus.redirect_valid = 1'b0;
    chk("hsr_valid_low", 32'(bus.out_valid), 32'd0);
    chk("hsr_addr", 32'(bus.mem_addr), 32'h200);
    wait_valid("hsr_latency", 5);

    // Reset while VALID with a redirect pending: reset wins.
    tick();
    bus.out_ready = 1'b0;
    chk("stall_addr", 32'(bus.mem_addr), 32'h204);
    wait_valid("stall_latency", 5);
    rst = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 10'h300;
    tick();
    chk("rst2_valid", 32'(bus.out_valid), 32'd0);
    chk("rst2_addr", 32'(bus.mem_addr), 32'h000);
    chk("rst2_pc", 32'(bus.out_pc), 32'd0);
    chk("rst2_instr", bus.out_instr, 32'd0);
    rst = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.out_ready = 1'b1;
    sbq.push_back('{instr: 32'h6B5ADDCC, pc: 10'h000});
    chk("rst2_issue_addr", 32'(bus.mem_addr), 32'h000);
    wait_valid("post_reset_latency", 5);
    tick();

    chk("handshake_count", 32'(hs_count), 32'd7);
    chk("queue_drained", 32'(sbq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
